tone_display_unit: RTL and testbench

TONE_DISPLAY_UNIT -- requirements
Module: tone_display_unit

---
 rtl/tone_display_unit_pkg.sv | 20 ++
 rtl/tone_display_unit_seg7.sv | 14 +
 rtl/tone_display_unit.sv | 101 ++++++++++
 tb/tb_tone_display_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/tone_display_unit_pkg.sv
// Shared constants for the tone/display unit: counter widths, scan timing
// default, blank code and the seven-segment glyph table.
package tone_display_unit_pkg;

    localparam int PWM_W            = 32;
    localparam int SCAN_W           = 32;
    localparam int IDX_W            = 3;
    localparam int DIGITS           = 8;
    localparam int LAMPS            = 7;
    localparam int SCAN_DIV_DEFAULT = 50000;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Segment order {dp,g,f,e,d,c,b,a}, active high; 10..15 render blank.
    localparam logic [7:0] GLYPH_TABLE [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/tone_display_unit_seg7.sv
// Combinational seven-segment glyph lookup for one hex nibble.
module seg7_decode
    import tone_display_unit_pkg::*;
(
    input  logic [3:0] value,
    output logic [7:0] segments
);

    // Table lookup; the decimal point is never lit by the table.
    always_comb begin
        segments = GLYPH_TABLE[value];
    end

endmodule

// File: rtl/tone_display_unit.sv
// Tone generator plus display driver: a free-running PWM with live period/duty,
// an eight-digit multiplexed seven-segment scanner showing num on the rightmost
// digit, and a one-of-seven lamp decoder.
module tone_display_unit
    import tone_display_unit_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [PWM_W-1:0]  period,
    input  logic [PWM_W-1:0]  duty,
    input  logic [3:0]        num,
    output logic              pwm_out,
    output logic [DIGITS-1:0] digit_enable,
    output logic [7:0]        segment_data,
    output logic [LAMPS-1:0]  lamp_data
);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    // ---------------- PWM ----------------
    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W:0]   pwm_cnt_inc;
    logic             pwm_reload;

    // Compare count+1 against period at 33 bits so a shrunken period (or
    // period 0) forces a reload instead of letting the counter run on to 2^32.
    always_comb begin
        pwm_cnt_inc = {1'b0, pwm_cnt} + {{PWM_W{1'b0}}, 1'b1};
        pwm_reload  = (pwm_cnt_inc >= {1'b0, period});
        pwm_out     = (period != '0) && (pwm_cnt < duty);
    end

    // PWM counter: counts up each clock, back to 0 after period-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= '0;
        end else if (pwm_reload) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt_inc[PWM_W-1:0];
        end
    end

    // ---------------- Display scanner ----------------
    logic [SCAN_W-1:0] scan_div;
    logic [SCAN_W-1:0] scan_div_nxt;
    logic [IDX_W-1:0]  scan_idx;
    logic [IDX_W-1:0]  scan_idx_nxt;
    logic              scan_live;
    logic [7:0]        glyph;

    seg7_decode u_seg7_decode (
        .value    (num),
        .segments (glyph)
    );

    // Next divider/index. The first clock out of reset only lights digit 0
    // (scan_live still 0), so every slot, including the first, lasts SCAN_DIV.
    always_comb begin
        scan_div_nxt = scan_div;
        scan_idx_nxt = scan_idx;
        if (scan_live) begin
            if (scan_div == SCAN_LAST) begin
                scan_div_nxt = '0;
                scan_idx_nxt = scan_idx + IDX_W'(1);
            end else begin
                scan_div_nxt = scan_div + SCAN_W'(1);
            end
        end
    end

    // Scanner state and registered digit/segment outputs, updated together so
    // the segment pattern always matches the enabled digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_live    <= 1'b0;
            scan_div     <= '0;
            scan_idx     <= '0;
            digit_enable <= '0;
            segment_data <= SEG_BLANK;
        end else begin
            scan_live    <= 1'b1;
            scan_div     <= scan_div_nxt;
            scan_idx     <= scan_idx_nxt;
            digit_enable <= DIGITS'(1) << scan_idx_nxt;
            segment_data <= (scan_idx_nxt == '0) ? glyph : SEG_BLANK;
        end
    end

    // ---------------- Lamps ----------------
    // Lamp k lights for num == k+1; 0 and 8..15 leave all lamps dark.
    always_comb begin
        for (int i = 0; i < LAMPS; i++) begin
            lamp_data[i] = (num == 4'(i + 1));
        end
    end

endmodule

// File: tb/tb_tone_display_unit.sv
// Directed + randomized bench for tone_display_unit with a behavioural model.
module tb_tone_display_unit;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] period;
    logic [31:0] duty;
    logic [3:0]  num;
    logic        pwm_out;
    logic [7:0]  digit_enable;
    logic [7:0]  segment_data;
    logic [6:0]  lamp_data;

    int tests = 0;
    int fails = 0;

    // Behavioural model state: PWM phase, clock edges since reset release,
    // and the num value captured at the most recent edge.
    logic [63:0] m_cnt;
    int          m_edges;
    logic [3:0]  m_seg_num;

    logic [7:0] glyph_ref [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    tone_display_unit #(.SCAN_DIV(SD)) dut (
        .clk          (clk),
        .rst          (rst),
        .period       (period),
        .duty         (duty),
        .num          (num),
        .pwm_out      (pwm_out),
        .digit_enable (digit_enable),
        .segment_data (segment_data),
        .lamp_data    (lamp_data)
    );

    always #5 clk = ~clk;

    function automatic int slot();
        return ((m_edges - 1) / SD) % 8;
    endfunction

    function automatic logic [31:0] exp_pwm();
        return (period != 0 && m_cnt < {32'b0, duty}) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] exp_de();
        if (m_edges == 0) return 32'd0;
        return 32'd1 << slot();
    endfunction

    function automatic logic [31:0] exp_seg();
        if (m_edges == 0) return 32'd0;
        return (slot() == 0) ? {24'b0, glyph_ref[m_seg_num]} : 32'd0;
    endfunction

    function automatic logic [31:0] exp_lamp();
        if (num >= 1 && num <= 7) return 32'd1 << (num - 1);
        return 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pwm"},  {31'b0, pwm_out},     exp_pwm());
        check({tag, ".de"},   {24'b0, digit_enable}, exp_de());
        check({tag, ".seg"},  {24'b0, segment_data}, exp_seg());
        check({tag, ".lamp"}, {25'b0, lamp_data},    exp_lamp());
    endtask

    // Advance one clock, update the model with the inputs seen at that edge.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst) begin
            if (period == 0 || m_cnt + 64'd1 >= {32'b0, period}) m_cnt = 0;
            else m_cnt = m_cnt + 64'd1;
            m_edges++;
            m_seg_num = num;
        end
        #1;
        check_all(tag);
    endtask

    task automatic apply(input logic [31:0] p, input logic [31:0] d, input logic [3:0] n, input string tag);
        period = p;
        duty   = d;
        num    = n;
        #1;
        check_all(tag);
    endtask

    initial begin
        rst       = 1'b0;
        period    = 32'd4;
        duty      = 32'd2;
        num       = 4'd5;
        m_cnt     = 0;
        m_edges   = 0;
        m_seg_num = 4'd0;

        // Held in reset: registered outputs zero, pwm from counter 0.
        #2 check_all("reset_hold");
        step("reset_hold");
        step("reset_hold");

        // Release between edges; first edge lights digit 0 with glyph(5).
        rst = 1'b1;
        #1 check_all("release");
        for (int i = 0; i < 12; i++) step("p4d2");
        apply(32'd4, 32'd3, 4'd5, "p4d3_apply");
        for (int i = 0; i < 8; i++) step("p4d3");
        apply(32'd4, 32'd0, 4'd5, "d0_apply");
        for (int i = 0; i < 8; i++) step("d0");
        apply(32'd0, 32'd5, 4'd5, "p0_apply");
        for (int i = 0; i < 8; i++) step("p0");
        apply(32'd4, 32'd9, 4'd5, "d9_apply");
        for (int i = 0; i < 8; i++) step("d9");
        apply(32'd1, 32'd1, 4'd5, "p1_apply");
        for (int i = 0; i < 4; i++) step("p1");

        // Full scan rotation with num=5.
        apply(32'd4, 32'd2, 4'd5, "scan_apply");
        for (int i = 0; i < 36; i++) step("scan");

        // Period shrinks while counter sits at 50.
        apply(32'd100, 32'd60, 4'd3, "shrink_setup");
        for (int i = 0; i < 200 && m_cnt != 64'd50; i++) step("shrink_run");
        apply(32'd10, 32'd5, 4'd3, "shrink_apply");
        for (int i = 0; i < 25; i++) step("shrink_after");

        // num sweep: wait for slot 0 holding the new value, then check glyph.
        for (int n = 0; n < 16; n++) begin
            int k;
            apply(32'd4, 32'd2, 4'(n), "sweep_apply");
            k = 0;
            do begin
                step("sweep");
                k++;
            end while (!(slot() == 0 && m_seg_num == 4'(n)) && k < 40);
        end

        // Randomized period/duty/num changes.
        for (int r = 0; r < 60; r++) begin
            int len;
            apply($urandom_range(12, 0), $urandom_range(14, 0), 4'($urandom_range(15, 0)), "rand_apply");
            len = $urandom_range(5, 1);
            for (int j = 0; j < len; j++) step("rand");
        end

        // Asynchronous reset pulse mid-period and mid-scan.
        apply(32'd7, 32'd3, 4'd8, "arst_setup");
        for (int i = 0; i < 10; i++) step("arst_pre");
        #1 rst = 1'b0;
        m_cnt   = 0;
        m_edges = 0;
        #1 check_all("arst_low");
        #1 rst = 1'b1;
        for (int i = 0; i < 10; i++) step("arst_post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
